// File: rtl/fetch_sequencer_if.sv
// Issue handshake from the fetch sequencer to the execute datapath.
// The sequencer is the master; the datapath answers with instr_ready.
interface fetch_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_out;

  modport master (
    output instr_valid,
    output instr_out,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_out,
    output instr_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program sequencer: owns the PC, fetches from the ROM, resolves
// BR/RET/HALT locally and issues everything else to the datapath.
module fetch_sequencer #(
  parameter int                ADDR_W    = 5,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_CODE = 8'hFF,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] instr,
  input  logic              cmp_flag,
  fetch_sequencer_if.master iss,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              busy,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_HALTED
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] ir;
  logic              is_halt;
  logic              is_br;
  logic              is_ret;
  logic              launch;
  logic              accept;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] pc_inc;

  assign is_halt = (ir == HALT_CODE);
  assign is_br   = (ir[DATA_W-1 -: 4] == 4'b1000);
  assign is_ret  = (ir[DATA_W-1 -: 4] == 4'b1011);
  assign tgt     = ADDR_W'(ir[3:0]);
  assign pc_inc  = pc + ADDR_W'(1);

  assign launch = start &&
                  (state == S_IDLE || state == S_HALTED);
  assign accept = (state == S_ISSUE) && iss.instr_ready;

  assign adr           = pc;
  assign iss.instr_out = ir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE,
      S_HALTED: if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_halt:       state_nxt = S_HALTED;
          is_br, is_ret: state_nxt = S_FETCH;
          default:       state_nxt = S_ISSUE;
        endcase
      end
      S_ISSUE:  if (iss.instr_ready) state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    iss.instr_valid = 1'b0;
    halted          = 1'b0;
    busy            = 1'b0;
    unique case (state)
      S_FETCH,
      S_DECODE: busy = 1'b1;
      S_ISSUE: begin
        busy            = 1'b1;
        iss.instr_valid = 1'b1;
      end
      S_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  // Control-flow words never leave this block and are not retired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      ir      <= '0;
      retired <= '0;
    end else begin
      if (launch) begin
        pc      <= RESET_PC;
        retired <= '0;
      end
      if (state == S_FETCH) ir <= instr;
      if (state == S_DECODE) begin
        if (is_br)       pc <= cmp_flag ? tgt : pc_inc;
        else if (is_ret) pc <= tgt;
      end
      if (accept) begin
        pc      <= pc_inc;
        retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized bench for fetch_sequencer against a
// program-level reference walk of the ROM contents.
module tb_fetch_sequencer;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cmp_flag = 1'b0;
  logic [AW-1:0] adr;
  logic [AW-1:0] pc;
  logic [DW-1:0] instr;
  logic          halted;
  logic          busy;
  logic [CW-1:0] retired;
  logic [DW-1:0] rom [32];

  int checks = 0;
  int errors = 0;

  int exp_pc [$];
  int exp_w  [$];
  bit m_halt;
  int m_halt_pc;

  fetch_sequencer_if #(.DATA_W(DW)) iss ();

  fetch_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .RESET_PC('0),
    .HALT_CODE(8'hFF), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .adr(adr), .instr(instr), .cmp_flag(cmp_flag),
    .iss(iss), .pc(pc), .halted(halted),
    .busy(busy), .retired(retired)
  );

  assign instr = rom[adr];

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  function automatic bit is_ctl(input logic [7:0] w);
    return w == 8'hFF || w[7:4] == 4'h8 || w[7:4] == 4'hB;
  endfunction

  function automatic logic [7:0] rand_plain();
    logic [7:0] w;
    do w = 8'($urandom); while (is_ctl(w));
    return w;
  endfunction

  // Walk the program as the ISA describes it.
  task automatic model(input bit flag);
    int p;
    logic [7:0] w;
    p = 0;
    exp_pc.delete();
    exp_w.delete();
    m_halt = 1'b0;
    m_halt_pc = 0;
    for (int s = 0; s < 2000 && exp_w.size() < 400; s++) begin
      w = rom[p];
      if (w == 8'hFF) begin
        m_halt = 1'b1;
        m_halt_pc = p;
        break;
      end else if (w[7:4] == 4'h8) begin
        p = flag ? int'(w[3:0]) : (p + 1) % 32;
      end else if (w[7:4] == 4'hB) begin
        p = int'(w[3:0]);
      end else begin
        exp_pc.push_back(p);
        exp_w.push_back(int'(w));
        p = (p + 1) % 32;
      end
    end
  endtask

  task automatic run_prog(input bit flag,
                          input int budget,
                          input int pct);
    int n;
    bit stall;
    logic [7:0] s_out;
    logic [4:0] s_pc;
    model(flag);
    cmp_flag = flag;
    iss.instr_ready = 1'b0;
    do_reset();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    stall = 1'b0;
    s_out = '0;
    s_pc = '0;
    for (int c = 0; c < budget && !halted; c++) begin
      iss.instr_ready = ($urandom_range(99) < pct);
      if (stall) begin
        chk("hold_valid", iss.instr_valid, 1);
        chk("hold_out", iss.instr_out, s_out);
        chk("hold_pc", pc, s_pc);
      end
      stall = 1'b0;
      if (iss.instr_valid && iss.instr_ready) begin
        if (n < exp_w.size()) begin
          chk("issue_word", iss.instr_out, exp_w[n]);
          chk("issue_pc", pc, exp_pc[n]);
        end else begin
          chk("issue_extra", n, exp_w.size());
        end
        n++;
      end else if (iss.instr_valid) begin
        stall = 1'b1;
        s_out = iss.instr_out;
        s_pc = pc;
      end
      step();
    end
    chk("run_retired", retired, n % 256);
    if (m_halt) begin
      chk("run_halted", halted, 1);
      chk("run_busy", busy, 0);
      chk("run_halt_pc", pc, m_halt_pc);
      chk("run_count", n, exp_w.size());
    end else begin
      chk("run_nohalt", halted, 0);
    end
  endtask

  initial begin
    int w;
    iss.instr_ready = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 8'h20 + 8'(i);
    #3;
    chk("rst_pc", pc, 0);
    chk("rst_valid", iss.instr_valid, 0);
    chk("rst_out", iss.instr_out, 0);
    chk("rst_halted", halted, 0);
    chk("rst_busy", busy, 0);
    chk("rst_retired", retired, 0);
    rst_n = 1'b1;
    step();

    // First issue latency, start ignored in DECODE, halt.
    rom[0] = 8'h93;
    rom[1] = 8'hFF;
    iss.instr_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("lat_c1_valid", iss.instr_valid, 0);
    chk("lat_c1_busy", busy, 1);
    chk("lat_c1_adr", adr, 0);
    step();
    chk("lat_c2_valid", iss.instr_valid, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("lat_c3_valid", iss.instr_valid, 1);
    chk("lat_c3_out", iss.instr_out, 8'h93);
    chk("lat_c3_adr", adr, 0);
    step();
    chk("lat_ret", retired, 1);
    chk("lat_adr", adr, 1);
    chk("lat_valid_low", iss.instr_valid, 0);
    step();
    step();
    chk("halt_flag", halted, 1);
    chk("halt_busy", busy, 0);
    chk("halt_pc", pc, 1);

    // Backpressure in ISSUE, with a stray start.
    do_reset();
    step();
    rom[0] = 8'h42;
    iss.instr_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", iss.instr_valid, 1);
      chk("bp_out", iss.instr_out, 8'h42);
      chk("bp_pc", pc, 0);
      chk("bp_ret", retired, 0);
      if (i == 1) start = 1'b1;
      step();
      start = 1'b0;
    end
    iss.instr_ready = 1'b1;
    step();
    chk("bp_accept_ret", retired, 1);
    chk("bp_accept_pc", pc, 1);
    chk("bp_accept_valid", iss.instr_valid, 0);

    // NOP program: PC wrap at 31 and counter wrap.
    do_reset();
    step();
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    iss.instr_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      w = 0;
      while (!iss.instr_valid && w < 8) begin
        step();
        w++;
      end
      chk("wrap_wait", iss.instr_valid, 1);
      step();
      chk("wrap_pc", pc, k % 32);
      chk("wrap_ret", retired, k % 256);
    end

    // Asynchronous reset between edges while issuing.
    w = 0;
    while (!iss.instr_valid && w < 8) begin
      step();
      w++;
    end
    chk("ar_pre_valid", iss.instr_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", iss.instr_valid, 0);
    chk("ar_pc", pc, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ret", retired, 0);
    #1;
    rst_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("ar_restart_valid", iss.instr_valid, 1);
    chk("ar_restart_pc", pc, 0);

    // Full program with BR at 5 and RETs at 9 and 13.
    for (int i = 0; i < 32; i++) rom[i] = 8'h20 + 8'(i);
    rom[0]  = 8'h93;
    rom[5]  = 8'h8B;
    rom[9]  = 8'hBE;
    rom[13] = 8'hB6;
    rom[30] = 8'hFF;
    run_prog(1'b1, 1000, 100);
    run_prog(1'b0, 1000, 60);
    run_prog(1'b1, 1000, 40);

    // Random programs.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 32; i++) begin
        w = $urandom_range(99);
        if (w < 12)      rom[i] = {4'h8, 4'($urandom)};
        else if (w < 18) rom[i] = {4'hB, 4'($urandom)};
        else             rom[i] = rand_plain();
      end
      if ($urandom_range(3) != 0)
        rom[$urandom_range(31, 16)] = 8'hFF;
      run_prog(1'($urandom_range(1)), 700, 70);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
